// File: rtl/collapse.sv
// Value-to-range collapser: merges runs of consecutive increasing values into
// (start, count) descriptors, one output register slot, valid/ready on both sides.
module collapse #(
  parameter int DATA_W  = 16,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DATA_W-1:0]  s_data,
  input  logic               s_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [DATA_W-1:0]  m_start,
  output logic [COUNT_W-1:0] m_count,
  output logic               m_last
);

  typedef enum logic [1:0] {IDLE, RUN, TAIL} state_t;

  localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};
  localparam logic [DATA_W:0]    DATA_ONE  = (DATA_W+1)'(1);

  state_t               state, state_next;
  logic [DATA_W-1:0]    acc_start, acc_start_next;
  logic [COUNT_W-1:0]   acc_count, acc_count_next;
  logic [DATA_W-1:0]    acc_next, acc_next_next;
  logic                 acc_wrap, acc_wrap_next;
  logic                 m_valid_next, m_last_next;
  logic [DATA_W-1:0]    m_start_next;
  logic [COUNT_W-1:0]   m_count_next;

  logic slot_free, ready_core, accept, contig;

  assign slot_free  = !m_valid || m_ready;
  // Reset gating lives only on the port; the flops are already held in reset.
  assign ready_core = (state != TAIL) && slot_free;
  assign s_ready    = rst && ready_core;
  assign accept     = s_valid && ready_core;
  assign contig     = (s_data == acc_next) && !acc_wrap && (acc_count != COUNT_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      acc_start <= '0;
      acc_count <= '0;
      acc_next  <= '0;
      acc_wrap  <= 1'b0;
      m_valid   <= 1'b0;
      m_start   <= '0;
      m_count   <= '0;
      m_last    <= 1'b0;
    end else begin
      state     <= state_next;
      acc_start <= acc_start_next;
      acc_count <= acc_count_next;
      acc_next  <= acc_next_next;
      acc_wrap  <= acc_wrap_next;
      m_valid   <= m_valid_next;
      m_start   <= m_start_next;
      m_count   <= m_count_next;
      m_last    <= m_last_next;
    end
  end

  always_comb begin
    state_next     = state;
    acc_start_next = acc_start;
    acc_count_next = acc_count;
    acc_next_next  = acc_next;
    acc_wrap_next  = acc_wrap;
    m_valid_next   = m_valid && !m_ready;
    m_start_next   = m_start;
    m_count_next   = m_count;
    m_last_next    = m_last;

    case (state)
      IDLE: begin
        if (accept) begin
          if (s_last) begin
            m_valid_next = 1'b1;
            m_start_next = s_data;
            m_count_next = COUNT_ONE;
            m_last_next  = 1'b1;
          end else begin
            acc_start_next                 = s_data;
            acc_count_next                 = COUNT_ONE;
            {acc_wrap_next, acc_next_next} = {1'b0, s_data} + DATA_ONE;
            state_next                     = RUN;
          end
        end
      end

      RUN: begin
        if (accept) begin
          if (contig) begin
            if (s_last) begin
              m_valid_next = 1'b1;
              m_start_next = acc_start;
              m_count_next = acc_count + COUNT_ONE;
              m_last_next  = 1'b1;
              state_next   = IDLE;
            end else begin
              acc_count_next                 = acc_count + COUNT_ONE;
              {acc_wrap_next, acc_next_next} = {1'b0, acc_next} + DATA_ONE;
            end
          end else begin
            // Close the current run and open a new one on the breaking beat.
            m_valid_next                   = 1'b1;
            m_start_next                   = acc_start;
            m_count_next                   = acc_count;
            m_last_next                    = 1'b0;
            acc_start_next                 = s_data;
            acc_count_next                 = COUNT_ONE;
            {acc_wrap_next, acc_next_next} = {1'b0, s_data} + DATA_ONE;
            if (s_last) state_next = TAIL;
          end
        end
      end

      TAIL: begin
        if (slot_free) begin
          m_valid_next = 1'b1;
          m_start_next = acc_start;
          m_count_next = acc_count;
          m_last_next  = 1'b1;
          state_next   = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_collapse.sv
// Scoreboard bench for collapse: directed packets, backpressure, random
// traffic against a run model, width-limit instances and mid-run reset.
module tb_collapse;

  typedef struct packed {
    logic [15:0] start;
    logic [15:0] count;
    logic        last;
  } desc_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Main instance, default widths
  logic        s_valid = 1'b0, s_last = 1'b0, s_ready;
  logic [15:0] s_data = '0;
  logic        m_valid, m_last;
  logic [15:0] m_start, m_count;
  logic        m_ready, ready_dir = 1'b1, ready_rnd = 1'b1, rand_ready = 1'b0;
  logic        rand_valid = 1'b0;
  assign m_ready = rand_ready ? ready_rnd : ready_dir;

  collapse dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_start(m_start),
    .m_count(m_count), .m_last(m_last));

  // Short count field
  logic        c4_s_valid = 1'b0, c4_s_last = 1'b0, c4_s_ready, c4_m_valid, c4_m_last;
  logic [15:0] c4_s_data = '0, c4_m_start;
  logic [3:0]  c4_m_count;
  logic        c4_m_ready = 1'b1;

  collapse #(.DATA_W(16), .COUNT_W(4)) dut_c4 (
    .clk(clk), .rst(rst), .s_valid(c4_s_valid), .s_ready(c4_s_ready), .s_data(c4_s_data),
    .s_last(c4_s_last), .m_valid(c4_m_valid), .m_ready(c4_m_ready), .m_start(c4_m_start),
    .m_count(c4_m_count), .m_last(c4_m_last));

  // Short data field
  logic        d8_s_valid = 1'b0, d8_s_last = 1'b0, d8_s_ready, d8_m_valid, d8_m_last;
  logic [7:0]  d8_s_data = '0, d8_m_start;
  logic [15:0] d8_m_count;
  logic        d8_m_ready = 1'b1;

  collapse #(.DATA_W(8), .COUNT_W(16)) dut_d8 (
    .clk(clk), .rst(rst), .s_valid(d8_s_valid), .s_ready(d8_s_ready), .s_data(d8_s_data),
    .s_last(d8_s_last), .m_valid(d8_m_valid), .m_ready(d8_m_ready), .m_start(d8_m_start),
    .m_count(d8_m_count), .m_last(d8_m_last));

  desc_t exp_q[$];
  desc_t exp_c4[$];
  desc_t exp_d8[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic desc_t mk(input int st, input int cnt, input bit l);
    desc_t d;
    d.start = 16'(st);
    d.count = 16'(cnt);
    d.last  = l;
    return d;
  endfunction

  // Reference run model: a run extends only on value+1 without wrap and below the count limit
  task automatic model_push(input int vals[$]);
    int st, cnt;
    st  = vals[0];
    cnt = 1;
    for (int i = 1; i < vals.size(); i++) begin
      if (vals[i] == st + cnt && st + cnt <= 65535 && cnt < 65535) cnt++;
      else begin
        exp_q.push_back(mk(st, cnt, 1'b0));
        st  = vals[i];
        cnt = 1;
      end
    end
    exp_q.push_back(mk(st, cnt, 1'b1));
  endtask

  task automatic send_beat(input int d, input bit l, output int stalls);
    int gap;
    if (rand_valid) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    s_valid = 1'b1;
    s_data  = 16'(d);
    s_last  = l;
    stalls  = 0;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      stalls++;
      if (stalls > 1000) begin
        check("s_ready_timeout", 64'(s_ready), 64'd1);
        break;
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic send_packet(input int vals[$], input bit use_model, output int stalls);
    int st;
    stalls = 0;
    if (use_model) model_push(vals);
    for (int i = 0; i < vals.size(); i++) begin
      send_beat(vals[i], i == vals.size() - 1, st);
      stalls += st;
    end
  endtask

  // Main scoreboard monitor plus hold-stability check under backpressure
  initial begin
    bit    pend = 1'b0;
    desc_t pdesc, cur, e;
    forever begin
      @(negedge clk);
      cur = '{start: m_start, count: m_count, last: m_last};
      if (!rst) begin
        pend = 1'b0;
        continue;
      end
      if (pend) check("m_hold", {m_valid, cur}, {1'b1, pdesc});
      if (m_valid && m_ready) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL unexpected_desc: observed %0h expected none", cur);
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("desc", 64'(cur), 64'(e));
        end
      end
      pend  = m_valid && !m_ready;
      pdesc = cur;
    end
  end

  initial begin
    desc_t cur, e;
    forever begin
      @(negedge clk);
      if (rst && c4_m_valid && c4_m_ready) begin
        cur = '{start: c4_m_start, count: {12'd0, c4_m_count}, last: c4_m_last};
        checks++;
        assert (exp_c4.size() > 0) else begin
          errors++;
          $error("FAIL c4_unexpected: observed %0h expected none", cur);
        end
        if (exp_c4.size() > 0) begin
          e = exp_c4.pop_front();
          check("c4_desc", 64'(cur), 64'(e));
        end
      end
    end
  end

  initial begin
    desc_t cur, e;
    forever begin
      @(negedge clk);
      if (rst && d8_m_valid && d8_m_ready) begin
        cur = '{start: {8'd0, d8_m_start}, count: d8_m_count, last: d8_m_last};
        checks++;
        assert (exp_d8.size() > 0) else begin
          errors++;
          $error("FAIL d8_unexpected: observed %0h expected none", cur);
        end
        if (exp_d8.size() > 0) begin
          e = exp_d8.pop_front();
          check("d8_desc", 64'(cur), 64'(e));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      ready_rnd = 1'($urandom_range(0, 1));
    end
  end

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || exp_c4.size() != 0 || exp_d8.size() != 0) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 64'(exp_q.size() + exp_c4.size() + exp_d8.size()), 64'd0);
  endtask

  initial begin
    int vals[$];
    int stalls, n, v;
    desc_t cur;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {m_valid, m_start, m_count, m_last}, 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_s_ready", 64'(s_ready), 64'd1);

    // 1: one contiguous packet
    exp_q.push_back(mk(5, 4, 1'b1));
    vals = '{5, 6, 7, 8};
    send_packet(vals, 1'b0, stalls);
    cur = '{start: m_start, count: m_count, last: m_last};
    check("t1_latency", {m_valid, cur}, {1'b1, mk(5, 4, 1'b1)});

    // 2: break mid-packet, contiguous last
    exp_q.push_back(mk(1, 3, 1'b0));
    exp_q.push_back(mk(10, 2, 1'b1));
    vals = '{1, 2, 3, 10, 11};
    send_packet(vals, 1'b0, stalls);
    check("t2_no_stall", 64'(stalls), 64'd0);
    check("t2_ready_after", 64'(s_ready), 64'd1);

    // 3: break on the last beat costs one TAIL cycle
    exp_q.push_back(mk(1, 2, 1'b0));
    exp_q.push_back(mk(9, 1, 1'b1));
    vals = '{1, 2, 9};
    send_packet(vals, 1'b0, stalls);
    cur = '{start: m_start, count: m_count, last: m_last};
    check("t3_first", {m_valid, cur}, {1'b1, mk(1, 2, 1'b0)});
    check("t3_tail_ready", 64'(s_ready), 64'd0);
    @(posedge clk); #1;
    cur = '{start: m_start, count: m_count, last: m_last};
    check("t3_trailer", {m_valid, cur}, {1'b1, mk(9, 1, 1'b1)});
    check("t3_ready_back", 64'(s_ready), 64'd1);
    exp_q.push_back(mk(4, 1, 1'b1));
    vals = '{4};
    send_packet(vals, 1'b0, stalls);
    cur = '{start: m_start, count: m_count, last: m_last};
    check("t3_singleton", {m_valid, cur}, {1'b1, mk(4, 1, 1'b1)});

    // 4: backpressure with {4,1,1} pending
    ready_dir = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("t4_ready_low", {s_ready, m_valid}, {1'b0, 1'b1});
    end
    @(posedge clk); #1;
    ready_dir = 1'b1;
    vals = '{6};
    send_packet(vals, 1'b1, stalls);

    // 4: random traffic against the run model
    rand_ready = 1'b1;
    rand_valid = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      vals.delete();
      n = $urandom_range(1, 8);
      v = ($urandom_range(0, 9) == 0) ? 65532 : $urandom_range(0, 65535);
      vals.push_back(v);
      for (int i = 1; i < n; i++) begin
        v = ($urandom_range(0, 3) != 0) ? ((v + 1) & 65535) : $urandom_range(0, 65535);
        vals.push_back(v);
      end
      send_packet(vals, 1'b1, stalls);
    end
    rand_ready = 1'b0;
    rand_valid = 1'b0;
    drain("t4_drain");

    // 5: count limit and data wrap on narrow instances
    exp_c4.push_back(mk(0, 15, 1'b0));
    exp_c4.push_back(mk(15, 5, 1'b1));
    for (int i = 0; i < 20; i++) begin
      c4_s_valid = 1'b1;
      c4_s_data  = 16'(i);
      c4_s_last  = (i == 19);
      n = 0;
      @(negedge clk);
      while (!c4_s_ready && n < 100) begin
        n++;
        @(negedge clk);
      end
      @(posedge clk); #1;
    end
    c4_s_valid = 1'b0;
    exp_d8.push_back(mk(8'hFE, 2, 1'b0));
    exp_d8.push_back(mk(8'h00, 1, 1'b1));
    for (int i = 0; i < 3; i++) begin
      d8_s_valid = 1'b1;
      d8_s_data  = (i == 0) ? 8'hFE : (i == 1) ? 8'hFF : 8'h00;
      d8_s_last  = (i == 2);
      n = 0;
      @(negedge clk);
      while (!d8_s_ready && n < 100) begin
        n++;
        @(negedge clk);
      end
      @(posedge clk); #1;
    end
    d8_s_valid = 1'b0;
    drain("t5_drain");

    // 6: asynchronous reset with a partial run and a pending descriptor
    ready_dir = 1'b1;
    send_beat(3, 1'b0, stalls);
    send_beat(4, 1'b0, stalls);
    send_beat(5, 1'b0, stalls);
    send_beat(20, 1'b0, stalls);
    ready_dir = 1'b0;
    check("t6_pending", 64'(m_valid), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_outputs", {m_valid, m_start, m_count, m_last}, 64'd0);
    check("t6_rst_s_ready", 64'(s_ready), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    ready_dir = 1'b1;
    @(posedge clk); #1;
    vals = '{7};
    send_packet(vals, 1'b1, stalls);
    cur = '{start: m_start, count: m_count, last: m_last};
    check("t6_after_rst", {m_valid, cur}, {1'b1, mk(7, 1, 1'b1)});
    drain("t6_drain");
    repeat (5) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
